// File: rtl/wb_sram16_if.sv
// Wishbone classic slave bus between a master and the wb_sram16 bridge.
// Signals:
//   wb_adr_i  byte address            wb_dat_i  write data
//   wb_we_i   write enable            wb_sel_i  byte lane selects
//   wb_stb_i  strobe                  wb_cyc_i  cycle
//   wb_dat_o  read data               wb_ack_o  acknowledge
// The _i/_o suffixes are from the slave's point of view.
interface wb_sram16_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_sram16.sv
// 32-bit Wishbone slave to 16-bit asynchronous SRAM bridge.
// Each 32-bit access is split into a LO half (bits 15:0, SRAM word addr even)
// and a HI half (bits 31:16, odd). Every output is a flop.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wb              Wishbone slave modport (wb_sram16_if)
//   sram_addr       SRAM word address
//   sram_dq_o/_i    SRAM write / read data, sram_dq_oe drives dq
//   sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  active-low strobes
//
// state   | meaning
// IDLE    | waiting for cyc && stb, request latched on acceptance
// LO      | accessing bits 15:0 (strobe phase, write hold, or ack cycle)
// HI      | accessing bits 31:16 (strobe phase, write hold, or ack cycle)
// RECOVER | one cycle after ack/abort, stb ignored
module wb_sram16 #(
  parameter int ADDR_W = 18,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  wb_sram16_if.slave        wb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, RECOVER} state_t;
  // Sub-phase inside LO/HI: strobing, write hold, or the ack cycle.
  typedef enum logic [1:0] {PH_STB, PH_HOLD, PH_ACK} phase_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W:2]     adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [15:0]         rd_lo_q, rd_lo_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_o_q, dat_o_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dq_o_q, dq_o_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;
  logic                half_done;
  logic                act;
  logic                hi;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb.wb_adr_i[31:ADDR_W+1], wb.wb_adr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rd_lo_d   = rd_lo_q;
    ack_d     = 1'b0;
    dat_o_d   = dat_o_q;
    addr_d    = addr_q;
    dq_o_d    = dq_o_q;
    half_done = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          we_d    = wb.wb_we_i;
          sel_d   = wb.wb_sel_i;
          adr_d   = wb.wb_adr_i[ADDR_W:2];
          dat_d   = wb.wb_dat_i;
          phase_d = PH_STB;
          cnt_d   = CNT_LOAD;
          if (!wb.wb_we_i || (|wb.wb_sel_i[1:0])) begin
            state_d = LO;
          end else if (|wb.wb_sel_i[3:2]) begin
            state_d = HI;
          end else begin
            // Write with no lanes: ack next cycle, no SRAM access.
            state_d = HI;
            phase_d = PH_ACK;
            ack_d   = 1'b1;
          end
        end
      end
      LO, HI: begin
        // Sticky: a cyc drop anywhere in the half cancels the rest.
        if (!wb.wb_cyc_i) abort_d = 1'b1;
        case (phase_q)
          PH_STB: begin
            if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
            else if (we_q)      phase_d = PH_HOLD;
            else                half_done = 1'b1;
          end
          PH_HOLD: half_done = 1'b1;
          PH_ACK:  state_d = RECOVER;
          default: state_d = RECOVER;
        endcase
        if (half_done) begin
          if (!we_q && state_q == LO) rd_lo_d = sram_dq_i;
          if (abort_q || !wb.wb_cyc_i) begin
            state_d = RECOVER;
          end else if (state_q == LO && (!we_q || (|sel_q[3:2]))) begin
            state_d = HI;
            phase_d = PH_STB;
            cnt_d   = CNT_LOAD;
          end else begin
            phase_d = PH_ACK;
            ack_d   = 1'b1;
            if (!we_q) dat_o_d = {sram_dq_i, rd_lo_q};
          end
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered from the next state so they line up with it.
    act    = (state_d == LO || state_d == HI) && (phase_d != PH_ACK);
    hi     = (state_d == HI);
    ce_n_d = ~act;
    oe_n_d = ~(act && !we_d);
    we_n_d = ~(act && we_d && phase_d == PH_STB);
    dq_oe_d = act && we_d;
    lb_n_d = 1'b1;
    ub_n_d = 1'b1;
    if (act) begin
      addr_d = {adr_d, hi};
      if (we_d) begin
        lb_n_d = hi ? ~sel_d[2] : ~sel_d[0];
        ub_n_d = hi ? ~sel_d[3] : ~sel_d[1];
        dq_o_d = hi ? dat_d[31:16] : dat_d[15:0];
      end else begin
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_STB;
      cnt_q   <= 4'd0;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      adr_q   <= '0;
      dat_q   <= 32'd0;
      rd_lo_q <= 16'd0;
      ack_q   <= 1'b0;
      dat_o_q <= 32'd0;
      addr_q  <= '0;
      dq_o_q  <= 16'd0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rd_lo_q <= rd_lo_d;
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_o_q;
  assign sram_addr   = addr_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_lb_n   = lb_n_q;
  assign sram_ub_n   = ub_n_q;

endmodule
